clk_en_gen: RTL

Parametrised clock-enable generator replacing the fabric-derived slow clock of the CPU top level. All logic stays on the single board clock. Each of NUM_CH channels produces a one-cycle enable pulse under a per-channel run-time mode: full rate, power-of-two divide, single-step from an asynchronous switch or button, or hold. Pipeline stages gate their registers with en[i] instead of being clocked by a divided clock.

---
 rtl/clk_en_gen_pkg.sv | 17 +
 rtl/clk_en_gen_step_sync.sv | 40 ++++
 rtl/clk_en_gen.sv | 110 +++++++++++
 3 files changed

// File: rtl/clk_en_gen_pkg.sv
// Shared definitions for the clock-enable generator: per-channel mode
// encoding and the derived width of one divide-tap field.
package clk_en_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_FULL = 2'b01,
    MODE_DIV  = 2'b10,
    MODE_STEP = 2'b11
  } mode_e;

  // Width needed to address any bit of the shared divide counter.
  function automatic int tap_width(input int cnt_width);
    return $clog2(cnt_width);
  endfunction

endpackage

// File: rtl/clk_en_gen_step_sync.sv
// Brings the asynchronous step switch into the clock domain and turns each
// rising edge into a one-cycle pulse, ignoring anything seen right after reset.
module step_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic step,
  output logic step_pulse
);

  localparam int ARM_COUNT = SYNC_STAGES + 1;
  localparam int ARM_W     = $clog2(ARM_COUNT + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic [ARM_W-1:0]       arm;
  logic                   armed;

  assign armed = (arm == ARM_W'(ARM_COUNT));

  // The arm counter masks the edge a switch already high at reset release
  // would otherwise produce as the synchroniser fills with ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
      prev <= 1'b0;
      arm  <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], step};
      prev <= sync[SYNC_STAGES-1];
      if (!armed) begin
        arm <= arm + ARM_W'(1);
      end
    end
  end

  assign step_pulse = armed & sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/clk_en_gen.sv
// Per-channel clock-enable generator running entirely on the board clock:
// full rate, power-of-two divide, synchronised single-step, or hold.
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int  CNT_WIDTH   = 26,
  parameter int  NUM_CH      = 2,
  parameter int  SYNC_STAGES = 2,
  localparam int TAP_W       = tap_width(CNT_WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2*NUM_CH-1:0]     mode,
  input  logic [TAP_W*NUM_CH-1:0] tap,
  input  logic                    step,
  output logic [NUM_CH-1:0]       en,
  output logic [NUM_CH-1:0]       slow_clk
);

  logic [CNT_WIDTH-1:0]    cnt;
  logic [2*NUM_CH-1:0]     mode_q;
  logic [TAP_W*NUM_CH-1:0] tap_q;
  logic                    step_pulse;
  logic [NUM_CH-1:0]       en_next;
  logic [NUM_CH-1:0]       slow_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      mode_q <= {NUM_CH{MODE_HOLD}};
      tap_q  <= '0;
    end else begin
      cnt    <= cnt + CNT_WIDTH'(1);
      mode_q <= mode;
      tap_q  <= tap;
    end
  end

  step_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_step_sync (
    .clk       (clk),
    .reset     (reset),
    .step      (step),
    .step_pulse(step_pulse)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mode_e                ch_mode;
    logic [TAP_W-1:0]     tap_raw;
    logic [TAP_W-1:0]     ch_tap;
    logic [CNT_WIDTH-1:0] div_mask;
    logic                 div_hit;
    logic                 ch_en;
    logic                 ch_slow;

    assign ch_mode = mode_e'(mode_q[2*i +: 2]);
    assign tap_raw = tap_q[TAP_W*i +: TAP_W];

    // Taps beyond the counter width fall back to the slowest real divide.
    always_comb begin
      ch_tap = tap_raw;
      if (32'(tap_raw) >= CNT_WIDTH) begin
        ch_tap = TAP_W'(CNT_WIDTH - 1);
      end
    end

    always_comb begin
      div_mask = '0;
      for (int j = 0; j < CNT_WIDTH; j++) begin
        div_mask[j] = (j <= 32'(ch_tap));
      end
    end

    assign div_hit = ((cnt & div_mask) == div_mask);

    always_comb begin
      ch_en   = 1'b0;
      ch_slow = slow_clk[i];
      unique case (ch_mode)
        MODE_HOLD: ch_en = 1'b0;
        MODE_FULL: ch_en = 1'b1;
        MODE_DIV: begin
          ch_en   = div_hit;
          ch_slow = cnt[ch_tap];
        end
        MODE_STEP: begin
          ch_en = step_pulse;
          if (step_pulse) begin
            ch_slow = ~slow_clk[i];
          end
        end
      endcase
    end

    assign en_next[i]   = ch_en;
    assign slow_next[i] = ch_slow;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en       <= '0;
      slow_clk <= '0;
    end else begin
      en       <= en_next;
      slow_clk <= slow_next;
    end
  end

endmodule
